// File: rtl/uart_mmio_tx.sv
// Memory-mapped UART transmitter: buffers core stores in a FIFO, sends 8N1.
// Ports: clk, rst_n, WEI, Rd_sel, WD[31:0] in; RD[31:0], tx, tx_busy out.
module uart_mmio_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WEI,
  input  logic        Rd_sel,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        tx,
  output logic        tx_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_MAX =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DEPTH_C =
    4'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            tx_q, tx_d;

  logic            fifo_full;
  logic            fifo_empty;
  logic            baud_end;
  logic            pop;
  logic            data_wr;
  logic            ctl_wr;
  logic            push;
  logic            unused_wd;

  assign unused_wd  = ^WD[31:9];

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == 4'd0);
  assign baud_end   = (baud_q == BAUD_MAX);

  assign data_wr = WEI & ~WD[8];
  assign ctl_wr  = WEI &  WD[8];

  // A pop on the same edge frees a slot,
  // so a full FIFO can still take a byte.
  assign push = data_wr & (~fifo_full | pop);

  // Transmit FSM: next state, baud/bit
  // counters and the head pop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = 3'd0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next
          // start bit: no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Line level is registered from the
  // current state, so it trails by a cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[bit_q];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO storage, pointers, count, overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = WD[7:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    if (ctl_wr) begin
      ovf_d = 1'b0;
    end else if (data_wr && !push) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
    end
  end

  // Payload needs no reset: count gates
  // every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != S_IDLE)
                 | ~fifo_empty;

  assign RD = Rd_sel
    ? {24'b0, count_q, ovf_q,
       fifo_empty, fifo_full, tx_busy}
    : 32'b0;

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Testbench for uart_mmio_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Frame monitor decodes tx and checks bytes against a scoreboard queue.
module tb_uart_mmio_tx;

  localparam int CPB = 4;

  logic        clk;
  logic        rst_n;
  logic        WEI;
  logic        Rd_sel;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        tx;
  logic        tx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_wr = 0;
  bit mon_en = 1'b1;

  logic [7:0] exp_q [$];

  uart_mmio_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .WEI(WEI),
    .Rd_sel(Rd_sel),
    .WD(WD),
    .RD(RD),
    .tx(tx),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // One store; captured at the next edge.
  task automatic wr(
    input logic [31:0] d,
    input bit          ok
  );
    WEI = 1'b1;
    WD  = d;
    if (ok && !d[8]) exp_q.push_back(d[7:0]);
    @(posedge clk);
    #1;
    last_wr = cyc;
    WEI = 1'b0;
  endtask

  // Wait for tx_busy to drop; exp<0 skips
  // the cycle-count check.
  task automatic wait_idle(
    input string tag,
    input int    base,
    input int    exp
  );
    int lim;
    lim = 0;
    @(negedge clk);
    while (tx_busy && lim < 3000) begin
      @(negedge clk);
      lim++;
    end
    chk({tag, "_idle"}, 32'(tx_busy), 32'd0);
    if (exp >= 0)
      chk({tag, "_cyc"}, cyc - base, exp);
  endtask

  // Frame monitor: start bit seen at first
  // negedge low, then bit centres every CPB.
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        @(negedge clk);
        chk("mon_start", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        chk("mon_stop", 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          chk("mon_unexp", 32'(b), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("mon_byte", 32'(b), 32'(e));
        end
      end
    end
  end

  initial begin
    int base;
    rst_n  = 1'b0;
    WEI    = 1'b0;
    Rd_sel = 1'b0;
    WD     = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_rd0", RD, 32'd0);
    Rd_sel = 1'b1;
    @(negedge clk);
    chk("rst_rd", RD, 32'h4);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    Rd_sel = 1'b0;
    @(posedge clk);
    #1;

    // Single byte A5: latency and frame length
    wr(32'h0000_00A5, 1);
    base = last_wr;
    @(negedge clk);
    chk("lat_k", 32'(tx), 32'd1);
    @(negedge clk);
    chk("lat_k1", 32'(tx), 32'd1);
    chk("lat_busy", 32'(tx_busy), 32'd1);
    @(negedge clk);
    chk("lat_k2", 32'(tx), 32'd0);
    // pop at k+1, 40-cycle frame
    wait_idle("a5", base, 41);
    chk("a5_q", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;

    // Three back-to-back bytes
    wr(32'h01, 1);
    base = last_wr;
    wr(32'h02, 1);
    wr(32'h03, 1);
    wait_idle("b2b", base, 121);
    chk("b2b_q", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;

    // Overflow: 6 writes, 1 popped + 4 held
    wr(32'h11, 1);
    base = last_wr;
    wr(32'h22, 1);
    wr(32'h33, 1);
    wr(32'h44, 1);
    wr(32'h55, 1);
    wr(32'h66, 0);
    Rd_sel = 1'b1;
    @(negedge clk);
    chk("ovf_rd", RD, 32'h4B);
    wr(32'h100, 0);
    @(negedge clk);
    chk("ovf_clr", RD, 32'h43);
    Rd_sel = 1'b0;
    wait_idle("ovf", base, 201);
    chk("ovf_q", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;

    // Write on the STOP-end pop edge while full
    wr(32'h81, 1);
    base = last_wr;
    wr(32'h82, 1);
    wr(32'h83, 1);
    wr(32'h84, 1);
    wr(32'h85, 1);
    while (cyc < base + 40) begin
      @(posedge clk);
      #1;
    end
    Rd_sel = 1'b1;
    @(negedge clk);
    chk("pp_pre", RD, 32'h43);
    wr(32'h86, 1);
    @(negedge clk);
    chk("pp_post", RD, 32'h43);
    Rd_sel = 1'b0;
    wait_idle("pp", base, 241);
    chk("pp_q", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;

    // Simultaneous write and read
    Rd_sel = 1'b1;
    WEI    = 1'b1;
    WD     = 32'h5A;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    chk("sim_pre", RD, 32'h4);
    @(posedge clk);
    #1;
    base = cyc;
    WEI = 1'b0;
    @(negedge clk);
    chk("sim_post", RD, 32'h11);
    Rd_sel = 1'b0;
    @(negedge clk);
    chk("sim_rd0", RD, 32'd0);
    wait_idle("sim", base, 41);
    chk("sim_q", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-frame
    mon_en = 1'b0;
    wr(32'h00, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("mr_low", 32'(tx), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mr_tx", 32'(tx), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    Rd_sel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mr_rd", RD, 32'h4);
    chk("mr_tx2", 32'(tx), 32'd1);
    chk("mr_busy", 32'(tx_busy), 32'd0);
    repeat (50) @(negedge clk);
    chk("mr_tx3", 32'(tx), 32'd1);
    chk("mr_rd2", RD, 32'h4);
    Rd_sel = 1'b0;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
